// File: rtl/alu_multibyte_ctrl_pkg.sv
// Shared types for the multi-byte ALU sequencer and its 8-bit ALU slice.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_LSL = 3'b110,
        OP_LSR = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/alu_multibyte_ctrl_if.sv
// Request/response bundle between the decode stage and the multi-byte ALU sequencer.
interface alu_multibyte_ctrl_if #(
    parameter int NBYTES = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic [8*NBYTES-1:0]   req_a;
    logic [8*NBYTES-1:0]   req_b;
    logic                  req_cin;
    logic                  abort;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [8*NBYTES-1:0]   rsp_y;
    logic                  rsp_c;
    logic                  rsp_z;
    logic                  rsp_n;
    logic                  rsp_v;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, abort, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_c, rsp_z, rsp_n, rsp_v, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, abort, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_c, rsp_z, rsp_n, rsp_v, rsp_err, busy
    );

endinterface

// File: rtl/alu_multibyte_ctrl_alu8.sv
// Combinational 8-bit ALU slice; outputs read as zero while disabled.
module alu_8
    import alu_pkg::*;
(
    input  logic             i_en,
    input  logic             i_update_flags,
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    input  alu_op_t          i_op,
    input  logic             i_cin,
    output logic [ALU_W-1:0] o_y,
    output logic             o_cout,
    output logic             o_z,
    output logic             o_n,
    output logic             o_v
);
    logic [ALU_W-1:0] w_b_eff;
    logic [ALU_W:0]   w_sum;

    // Subtract is add of the inverted operand; the caller supplies the +1 via carry-in.
    always_comb begin
        w_b_eff = (i_op == OP_SUB) ? ~i_b : i_b;
        w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{ALU_W{1'b0}}, i_cin};
        o_y     = '0;
        o_cout  = 1'b0;
        o_v     = 1'b0;
        if (i_en) begin
            case (i_op)
                OP_ADD, OP_SUB: begin
                    o_y    = w_sum[ALU_W-1:0];
                    o_cout = w_sum[ALU_W];
                    o_v    = (i_a[ALU_W-1] == w_b_eff[ALU_W-1]) && (o_y[ALU_W-1] != i_a[ALU_W-1]);
                end
                OP_AND:  o_y = i_a & i_b;
                OP_OR:   o_y = i_a | i_b;
                OP_XOR:  o_y = i_a ^ i_b;
                OP_NOT:  o_y = ~i_a;
                default: o_y = '0;
            endcase
        end
        o_z = i_en && i_update_flags && (o_y == '0);
        o_n = i_en && i_update_flags && o_y[ALU_W-1];
        if (!i_update_flags) begin
            o_cout = 1'b0;
            o_v    = 1'b0;
        end
    end

endmodule

// File: rtl/alu_multibyte_ctrl.sv
// Byte-serial sequencer running NBYTES-wide operations through one alu_8, LSB first.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RUN   | one byte per cycle through alu_8 (unsupported opcodes pass through once, ALU off)
// DONE  | response held on rsp_* until rsp_ready or abort
module alu_multibyte_ctrl
    import alu_pkg::*;
#(
    parameter int NBYTES = 4
)(
    input  logic                 clk,
    input  logic                 rst_n,
    alu_multibyte_ctrl_if.slave  bus
);
    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    ctrl_state_t     r_state;
    ctrl_state_t     w_state_next;
    alu_op_t         r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_y;
    logic [KW-1:0]   r_k;
    logic            r_carry;
    logic            r_zacc;
    logic            r_c;
    logic            r_n;
    logic            r_v;
    logic            r_err;

    logic             w_accept;
    logic             w_last;
    logic             w_done;
    logic             w_alu_en;
    logic [ALU_W-1:0] w_alu_a;
    logic [ALU_W-1:0] w_alu_b;
    logic [ALU_W-1:0] w_alu_y;
    logic             w_alu_cout;
    logic             w_alu_z;
    logic             w_alu_n;
    logic             w_alu_v;

    assign w_accept = bus.req_valid && (r_state == IDLE);
    assign w_last   = (r_k == KW'(NBYTES - 1));
    assign w_done   = (r_state == DONE);
    assign w_alu_en = (r_state == RUN) && !r_err;
    assign w_alu_a  = r_a[{r_k, 3'b000} +: ALU_W];
    assign w_alu_b  = r_b[{r_k, 3'b000} +: ALU_W];

    alu_8 u_alu (
        .i_en           (w_alu_en),
        .i_update_flags (w_alu_en),
        .i_a            (w_alu_a),
        .i_b            (w_alu_b),
        .i_op           (r_op),
        .i_cin          (r_carry),
        .o_y            (w_alu_y),
        .o_cout         (w_alu_cout),
        .o_z            (w_alu_z),
        .o_n            (w_alu_n),
        .o_v            (w_alu_v)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort wins over rsp_ready and is ignored in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = RUN;
            RUN: begin
                if (bus.abort)            w_state_next = IDLE;
                else if (r_err || w_last) w_state_next = DONE;
            end
            DONE: if (bus.abort || bus.rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand latch on accept, then byte-serial accumulation of result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_y     <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_zacc  <= 1'b0;
            r_c     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_op    <= alu_op_t'(bus.req_op);
            r_a     <= bus.req_a;
            r_b     <= bus.req_b;
            r_y     <= '0;
            r_k     <= '0;
            r_carry <= bus.req_cin;
            r_zacc  <= (bus.req_op[2:1] != 2'b11);
            r_c     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
            r_err   <= (bus.req_op[2:1] == 2'b11);
        end else if (w_alu_en) begin
            r_y[{r_k, 3'b000} +: ALU_W] <= w_alu_y;
            r_carry <= w_alu_cout;
            r_zacc  <= r_zacc & w_alu_z;
            r_k     <= r_k + 1'b1;
            if (w_last) begin
                r_c <= w_alu_cout;
                r_n <= w_alu_n;
                r_v <= w_alu_v;
            end
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.busy      = (r_state == RUN) || w_done;
    assign bus.rsp_valid = w_done;
    assign bus.rsp_y     = w_done ? r_y : '0;
    assign bus.rsp_c     = w_done && r_c;
    assign bus.rsp_z     = w_done && r_zacc;
    assign bus.rsp_n     = w_done && r_n;
    assign bus.rsp_v     = w_done && r_v;
    assign bus.rsp_err   = w_done && r_err;

endmodule

// File: tb/tb_alu_multibyte_ctrl.sv
// Scoreboard bench for alu_multibyte_ctrl with NBYTES=4.
module tb_alu_multibyte_ctrl;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct packed {
        logic         err;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
        logic [W-1:0] y;
    } rsp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    rsp_t exp_q[$];

    alu_multibyte_ctrl_if #(.NBYTES(NB)) bus ();

    alu_multibyte_ctrl #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // Word-level reference: the byte-serial carry chain must equal a full-width add.
    function automatic rsp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
        rsp_t         r;
        logic [W:0]   s;
        logic [W-1:0] bb;
        r  = '0;
        bb = (op == 3'b001) ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + (W+1)'(cin);
        case (op)
            3'b000, 3'b001: begin
                r.y = s[W-1:0];
                r.c = s[W];
                r.v = (a[W-1] == bb[W-1]) && (r.y[W-1] != a[W-1]);
            end
            3'b010:  r.y = a & b;
            3'b011:  r.y = a | b;
            3'b100:  r.y = a ^ b;
            3'b101:  r.y = ~a;
            default: r.err = 1'b1;
        endcase
        if (!r.err) begin
            r.z = (r.y == '0);
            r.n = r.y[W-1];
        end
        return r;
    endfunction

    function automatic rsp_t sample();
        rsp_t r;
        r.err = bus.rsp_err;
        r.c   = bus.rsp_c;
        r.z   = bus.rsp_z;
        r.n   = bus.rsp_n;
        r.v   = bus.rsp_v;
        r.y   = bus.rsp_y;
        return r;
    endfunction

    // Drive one request through the accept edge; optionally record its expected response.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input bit push);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (push) exp_q.push_back(model(op, a, b, cin));
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=0 after %0d edges, required 1", lat);
        end
    endtask

    task automatic take();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [2+$bits(rsp_t)-1+1:0] got, expv;
        rst_n = 1'b0;
        #1;
        got  = {bus.req_ready, bus.rsp_valid, bus.busy, sample()};
        expv = {1'b1, 1'b0, 1'b0, {$bits(rsp_t){1'b0}}};
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", got, expv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int   lat;
        rsp_t got, expv;
        issue(3'b000, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
        wait_rsp(lat);
        checks++;
        if (lat !== NB) begin
            errors++;
            $display("FAIL add_latency: got %0d edges required %0d", lat, NB);
        end
        got = sample(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL add_result: got %h required %h", got, expv);
        end
        take();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_release: rsp_valid=%b req_ready=%b required 0 1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_sub();
        int   lat;
        rsp_t got, expv;
        issue(3'b001, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
        wait_rsp(lat);
        got = sample(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL sub_result: got %h required %h", got, expv);
        end
        take();
    endtask

    task automatic test_overflow();
        int   lat;
        rsp_t got, expv;
        issue(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        wait_rsp(lat);
        got = sample(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL add_signed_ovf: got %h required %h", got, expv);
        end
        take();
        issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        wait_rsp(lat);
        got = sample(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL add_carry_out: got %h required %h", got, expv);
        end
        take();
    endtask

    task automatic test_logic();
        int   lat;
        rsp_t got, expv;
        issue(3'b100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b1);
        wait_rsp(lat);
        got = sample(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL xor_zero: got %h required %h", got, expv);
        end
        take();
        issue(3'b101, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1, 1'b1);
        wait_rsp(lat);
        got = sample(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL not_result: got %h required %h", got, expv);
        end
        take();
        issue(3'b010, 32'hFF00_F0F0, 32'h8F0F_FF0F, 1'b1, 1'b1);
        wait_rsp(lat);
        got = sample(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL and_result: got %h required %h", got, expv);
        end
        take();
        issue(3'b011, 32'h1200_0034, 32'h0056_7800, 1'b0, 1'b1);
        wait_rsp(lat);
        got = sample(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL or_result: got %h required %h", got, expv);
        end
        take();
    endtask

    task automatic test_err();
        int   lat;
        rsp_t got, expv;
        for (int i = 0; i < 2; i++) begin
            issue((i == 0) ? 3'b110 : 3'b111, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
            wait_rsp(lat);
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL err_latency_%0d: got %0d edges required 1", i, lat);
            end
            got = sample(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL err_result_%0d: got %h required %h", i, got, expv);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        rsp_t got, expv, s0;
        issue(3'b001, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b1);
        wait_rsp(lat);
        s0 = sample();
        // Inputs outside IDLE must be ignored.
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b000;
        bus.req_a     = 32'hFFFF_FFFF;
        bus.req_b     = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (sample() !== s0 || bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle_%0d: rsp=%h valid=%b ready=%b required %h 1 0",
                         i, sample(), bus.rsp_valid, bus.req_ready, s0);
            end
        end
        bus.req_valid = 1'b0;
        got = sample(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL hold_result: got %h required %h", got, expv);
        end
        take();
    endtask

    task automatic test_abort();
        int   lat;
        bit   seen;
        rsp_t got, expv;
        // Abort while byte 2 is being processed.
        issue(3'b000, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_run: valid=%b ready=%b busy=%b required 0 1 0",
                     bus.rsp_valid, bus.req_ready, bus.busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_rsp: rsp_valid seen=%b required 0", seen);
        end
        // Abort in DONE beats rsp_ready and drops the response.
        issue(3'b100, 32'h0F0F_0000, 32'h00FF_00FF, 1'b0, 1'b0);
        wait_rsp(lat);
        bus.abort     = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.abort     = 1'b0;
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_done: valid=%b ready=%b required 0 1", bus.rsp_valid, bus.req_ready);
        end
        // Abort in IDLE is ignored: the request is still accepted and completes.
        bus.abort = 1'b1;
        issue(3'b000, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        bus.abort = 1'b0;
        wait_rsp(lat);
        checks++;
        if (lat !== NB) begin
            errors++;
            $display("FAIL abort_idle_latency: got %0d edges required %0d", lat, NB);
        end
        got = sample(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL abort_idle_result: got %h required %h", got, expv);
        end
        take();
    endtask

    task automatic test_reset_mid_run();
        logic [2+$bits(rsp_t)-1+1:0] got, expv;
        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        got  = {bus.req_ready, bus.rsp_valid, bus.busy, sample()};
        expv = {1'b1, 1'b0, 1'b0, {$bits(rsp_t){1'b0}}};
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL reset_mid_run: got %h required %h", got, expv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int           lat;
        rsp_t         got, expv;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic         cin;
        issue(3'(($urandom_range(0, 5))), W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 8; i++) begin
            wait_rsp(lat);
            got = sample(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL b2b_result_%0d: got %h required %h", i, got, expv);
            end
            op  = 3'($urandom_range(0, 5));
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            // New request already waiting while the response is taken.
            bus.req_op    = op;
            bus.req_a     = a;
            bus.req_b     = b;
            bus.req_cin   = cin;
            bus.req_valid = 1'b1;
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
            checks++;
            if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_turnaround_%0d: ready=%b busy=%b required 1 0", i, bus.req_ready, bus.busy);
            end
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            exp_q.push_back(model(op, a, b, cin));
        end
        wait_rsp(lat);
        got = sample(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL b2b_result_last: got %h required %h", got, expv);
        end
        take();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = 1'b0;
        bus.abort     = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_logic();
        test_err();
        test_backpressure();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
